// File: rtl/mc_core_if.sv
// Memory request/ack port and console valid/ready port of mc_core.
// master = core side, slave = memory model / console sink side.
interface mc_core_if #(
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [14:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/mc_core.sv
// Multi-cycle core with a shared req/ack memory port and a valid/ready console port.
// Define MC_CORE_PERF_EN to implement the retired-instruction counter; otherwise it reads 0.
module mc_core #(
  parameter int          DATA_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  mc_core_if.master   bus,
  output logic        halted_o,
  output logic [31:0] retired_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_MOVL = 4'h8;
  localparam logic [3:0] OP_MOVH = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_MEM  = 4'hF;

  state_e            state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] regs_q [16];
  logic              rf_we;

  logic [3:0]        op, ra, rb, rt;
  logic [7:0]        imm;
  logic [15:0]       pc_inc;
  logic              is_st;
  logic              valid_op;
  logic              jmp_take;
  logic [3:0]        rdb_idx;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign op      = ir_q[15:12];
  assign ra      = ir_q[11:8];
  assign rb      = ir_q[7:4];
  assign rt      = ir_q[3:0];
  assign imm     = ir_q[11:4];
  assign pc_inc  = pc_q + 16'd2;
  assign is_st   = rb[0];
  assign rdb_idx = (op == OP_SUB) ? rb : rt;
  assign rd_a    = (ra == 4'd0) ? '0 : regs_q[ra];
  assign rd_b    = (rdb_idx == 4'd0) ? '0 : regs_q[rdb_idx];

  always_comb begin
    valid_op = 1'b0;
    case (op)
      OP_SUB, OP_MOVL, OP_MOVH: valid_op = 1'b1;
      OP_JMP:                   valid_op = (rb <= 4'd3);
      OP_MEM:                   valid_op = (rb <= 4'd1);
      default:                  valid_op = 1'b0;
    endcase
  end

  always_comb begin
    jmp_take = 1'b0;
    case (rb[1:0])
      2'd0:    jmp_take = (opa_q == '0);
      2'd1:    jmp_take = (opa_q != '0);
      2'd2:    jmp_take = opa_q[DATA_W-1];
      default: jmp_take = ~opa_q[DATA_W-1];
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    rf_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata[15:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = rd_a;
        opb_d   = rd_b;
        state_d = valid_op ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op)
          OP_SUB:  res_d = opa_q - opb_q;
          OP_MOVL: res_d = {{(DATA_W-8){imm[7]}}, imm};
          OP_MOVH: begin
            res_d       = opb_q;
            res_d[15:8] = imm;
          end
          OP_JMP: begin
            pc_d    = jmp_take ? opb_q[15:0] : pc_inc;
            state_d = S_FETCH;
          end
          default: state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          if (is_st) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            res_d   = bus.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (rt != 4'd0) begin
          rf_we   = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else if (bus.out_ready) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      if (rf_we) regs_q[rt] <= res_q;
    end
  end

  // Outputs are forced low during reset because state is only cleared at the first reset edge.
  assign bus.mem_req   = ~rst_i & ((state_q == S_FETCH) | (state_q == S_MEM));
  assign bus.mem_we    = ~rst_i & (state_q == S_MEM) & is_st;
  assign bus.mem_addr  = rst_i ? '0 : ((state_q == S_MEM) ? opa_q[15:1] : pc_q[15:1]);
  assign bus.mem_wdata = rst_i ? '0 : opb_q;
  assign bus.out_valid = ~rst_i & (state_q == S_WB) & (rt == 4'd0);
  assign bus.out_data  = rst_i ? '0 : res_q[7:0];
  assign halted_o      = ~rst_i & (state_q == S_HALT);

`ifdef MC_CORE_PERF_EN
  logic        retire;
  logic [31:0] retired_q;

  assign retire = ((state_q == S_EXEC) & (op == OP_JMP))
                | ((state_q == S_MEM) & is_st & bus.mem_ack)
                | ((state_q == S_WB) & ((rt != 4'd0) | bus.out_ready));

  always_ff @(posedge clk_i) begin
    if (rst_i) retired_q <= '0;
    else if (retire) retired_q <= retired_q + 32'd1;
  end

  assign retired_o = rst_i ? '0 : retired_q;
`else
  assign retired_o = 32'h0;
`endif

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core (DATA_W=32) with a variable-latency memory model and console sink.
module tb_mc_core;
  localparam int DW = 32;
`ifdef MC_CORE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] retired;

  mc_core_if #(.DATA_W(DW)) bus ();

  mc_core #(.DATA_W(DW), .RESET_PC(16'h0000)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .halted_o  (halted),
    .retired_o (retired)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [14:0] addr; logic [15:0] dly; } fe_t;
  typedef struct packed { logic [14:0] addr; logic [31:0] data; } st_t;

  fe_t        exp_fetch[$];
  st_t        exp_st[$];
  logic [7:0] exp_out[$];

  logic [31:0] mem [0:255];
  int          wait_n    = 0;
  bit          ack_force = 1'b0;
  int          fetch_cnt = 0;
  int unsigned last_fetch_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ret(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic ef(input int a, input int d);
    exp_fetch.push_back('{addr: 15'(a), dly: 16'(d)});
  endtask

  task automatic es(input int a, input logic [31:0] d);
    exp_st.push_back('{addr: 15'(a), data: d});
  endtask

  task automatic put(input int a, input logic [15:0] w);
    mem[a] = {16'h0, w};
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Memory model: ack after wait_n wait cycles, stability checks during waits.
  bit          busy = 1'b0, done_pending = 1'b0, ack_n;
  int          wcnt = 0;
  logic [14:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;

  always @(negedge clk) begin : resp
    fe_t f;
    st_t s;
    if (done_pending) begin
      if (cap_we) begin
        mem[cap_addr[7:0]] = cap_wdata;
        if (exp_st.size() == 0) chk("store_unexpected", cap_addr, 15'h7fff);
        else begin
          s = exp_st.pop_front();
          chk("store_addr", cap_addr, s.addr);
          chk("store_data", cap_wdata, s.data);
        end
      end
      busy = 1'b0;
    end
    done_pending = 1'b0;
    ack_n = 1'b0;
    if (bus.mem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        wcnt      = 0;
        cap_addr  = bus.mem_addr;
        cap_we    = bus.mem_we;
        cap_wdata = bus.mem_wdata;
        if (!bus.mem_we && bus.mem_addr < 15'h40) begin
          if (exp_fetch.size() == 0) chk("fetch_unexpected", bus.mem_addr, 15'h7fff);
          else begin
            f = exp_fetch.pop_front();
            chk("fetch_addr", bus.mem_addr, f.addr);
            if (f.dly != 0) chk("fetch_latency", cyc - last_fetch_cyc, f.dly);
          end
          last_fetch_cyc = cyc;
          fetch_cnt++;
        end
      end else begin
        wcnt++;
        chk("hold_addr", bus.mem_addr, cap_addr);
        chk("hold_we", bus.mem_we, cap_we);
        chk("hold_wdata", bus.mem_wdata, cap_wdata);
      end
      ack_n = (wcnt >= wait_n);
    end else begin
      busy = 1'b0;
    end
    bus.mem_rdata = ack_n ? mem[cap_addr[7:0]] : 32'hDEAD_BEEF;
    bus.mem_ack   = ack_n | ack_force;
    done_pending  = ack_n & bus.mem_req & ~rst;
  end

  always @(negedge clk) begin : sink
    logic [7:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_out.size() == 0) chk("console_unexpected", bus.out_data, 9'h1ff);
      else begin
        e = exp_out.pop_front();
        chk("console_data", bus.out_data, e);
      end
    end
  end

  task automatic start_test();
    exp_fetch.delete();
    exp_st.delete();
    exp_out.delete();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_1000;
    fetch_cnt = 0;
    last_fetch_cyc = 0;
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b1;
    step();
    step();
    chk({tag, "_rst_req"}, bus.mem_req, 1'b0);
    chk({tag, "_rst_we"}, bus.mem_we, 1'b0);
    chk({tag, "_rst_addr"}, bus.mem_addr, 15'h0);
    chk({tag, "_rst_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_rst_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_rst_data"}, bus.out_data, 8'h0);
    chk({tag, "_rst_halted"}, halted, 1'b0);
    chk({tag, "_rst_retired"}, retired, 32'h0);
  endtask

  task automatic wait_halt(input string tag);
    int k = 0;
    while (!halted && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_halt_reached"}, halted, 1'b1);
  endtask

  task automatic end_checks(input string tag, input int n_ret);
    step();
    chk({tag, "_retired"}, retired, exp_ret(n_ret));
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_halt_sticky"}, halted, 1'b1);
      chk({tag, "_halt_noreq"}, bus.mem_req, 1'b0);
    end
    chk({tag, "_fetch_left"}, exp_fetch.size(), 0);
    chk({tag, "_store_left"}, exp_st.size(), 0);
    chk({tag, "_console_left"}, exp_out.size(), 0);
  endtask

  task automatic load_arith();
    put(0, 16'h8051);  // movl r1,#5
    put(1, 16'h8032);  // movl r2,#3
    put(2, 16'h0120);  // sub r0,r1,r2
    put(3, 16'h0210);  // sub r0,r2,r1
    put(4, 16'h1000);  // invalid
  endtask

  initial begin
    int k;
    bus.out_ready = 1'b1;

    // arithmetic and console, zero wait
    start_test();
    load_arith();
    ef(0, 0); ef(1, 4); ef(2, 4); ef(3, 4); ef(4, 4);
    exp_out.push_back(8'h02);
    exp_out.push_back(8'hFE);
    wait_n = 0;
    reset_dut("t1");
    rst = 1'b0;
    k = 0;
    while (fetch_cnt < 5 && k < 200) begin
      step();
      k++;
    end
    chk("t1_fetch_count", fetch_cnt, 5);
    chk("t1_decode_not_halted", halted, 1'b0);
    step();
    chk("t1_halt_next_edge", halted, 1'b1);
    chk("t1_halt_req", bus.mem_req, 1'b0);
    end_checks("t1", 4);

    // movl sign extension and movh merge, observed through a store
    start_test();
    put(0, 16'h8FF1);  // movl r1,#-1
    put(1, 16'h9121);  // movh r1,#12
    put(2, 16'h8405);  // movl r5,#0x40
    put(3, 16'hF511);  // st [r5],r1
    ef(0, 0); ef(1, 4); ef(2, 4); ef(3, 4); ef(4, 4);
    es(15'h20, 32'hFFFF_12FF);
    reset_dut("t2");
    rst = 1'b0;
    wait_halt("t2");
    end_checks("t2", 4);

    // st/ld round trip at byte 0x100 with three wait cycles per request
    start_test();
    put(0, 16'h9016);  // movh r6,#01 -> 0x100
    put(1, 16'h8EF7);  // movl r7,#EF
    put(2, 16'h9BE7);  // movh r7,#BE
    put(3, 16'hF617);  // st [r6],r7
    put(4, 16'hF608);  // ld r8,[r6]
    put(5, 16'h8609);  // movl r9,#0x60
    put(6, 16'hF918);  // st [r9],r8
    ef(0, 0); ef(1, 7); ef(2, 7); ef(3, 7); ef(4, 10); ef(5, 11); ef(6, 7); ef(7, 10);
    es(15'h80, 32'hFFFF_BEEF);
    es(15'h30, 32'hFFFF_BEEF);
    wait_n = 3;
    reset_dut("t3");
    rst = 1'b0;
    wait_halt("t3");
    end_checks("t3", 7);

    // jumps: taken/not taken on zero and sign
    start_test();
    put(0, 16'h8404);     // movl r4,#0x40
    put(1, 16'h8605);     // movl r5,#0x60
    put(2, 16'hE304);     // jz r3,r4 (taken)
    put(8'h20, 16'hE314); // jnz r3,r4 (not taken)
    put(8'h21, 16'h8FE3); // movl r3,#-2
    put(8'h22, 16'h97F3); // movh r3,#7F -> FFFF7FFE
    put(8'h23, 16'hE334); // jns r3,r4 (not taken)
    put(8'h24, 16'hE325); // js r3,r5 (taken)
    put(8'h30, 16'h0340); // sub r0,r3,r4
    ef(0, 0); ef(1, 4); ef(2, 4); ef(8'h20, 3); ef(8'h21, 3);
    ef(8'h22, 4); ef(8'h23, 4); ef(8'h24, 3); ef(8'h30, 3); ef(8'h31, 4);
    exp_out.push_back(8'hBE);
    wait_n = 0;
    reset_dut("t4");
    rst = 1'b0;
    wait_halt("t4");
    end_checks("t4", 9);

    // console backpressure
    start_test();
    put(0, 16'h85A0);  // movl r0,#5A
    put(1, 16'h8011);  // movl r1,#1
    ef(0, 0); ef(1, 0); ef(2, 4);
    exp_out.push_back(8'h5A);
    bus.out_ready = 1'b0;
    reset_dut("t5");
    rst = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      step();
      k++;
    end
    chk("t5_valid_seen", bus.out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t5_valid_held", bus.out_valid, 1'b1);
      chk("t5_data_held", bus.out_data, 8'h5A);
      chk("t5_no_fetch", bus.mem_req, 1'b0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("t5_valid_drop", bus.out_valid, 1'b0);
    chk("t5_next_fetch_req", bus.mem_req, 1'b1);
    chk("t5_next_fetch_addr", bus.mem_addr, 15'h1);
    wait_halt("t5");
    end_checks("t5", 2);

    // reset during a pending fetch with an ack arriving in reset
    start_test();
    load_arith();
    ef(0, 0);
    wait_n = 2;
    reset_dut("t6a");
    rst = 1'b0;
    step();
    chk("t6_fetch_started", fetch_cnt, 1);
    rst = 1'b1;
    ack_force = 1'b1;
    step();
    chk("t6_rst_req", bus.mem_req, 1'b0);
    chk("t6_rst_halted", halted, 1'b0);
    step();
    ack_force = 1'b0;
    ef(0, 0); ef(1, 6); ef(2, 6); ef(3, 6); ef(4, 6);
    exp_out.push_back(8'h02);
    exp_out.push_back(8'hFE);
    rst = 1'b0;
    wait_halt("t6");
    end_checks("t6", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
